// File: rtl/neuron_layer_mac_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the fully-connected layer MAC:
//   - layer_state_e : control FSM states of neuron_layer_mac
//   - default width / shift constants used as parameter defaults
//   - sat_to_width  : clamp a wide signed value into a signed field of 'width'
//   - relu          : clamp negative values to zero
// -----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINAL  = 2'd2,
        OUTPUT = 2'd3
    } layer_state_e;

    localparam int DEF_NUM_INPUTS   = 784;
    localparam int DEF_NUM_NEURONS  = 10;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_ACC_WIDTH    = 20;
    localparam int DEF_OUT_WIDTH    = 11;
    localparam int DEF_SHIFT        = 5;
    localparam int DEF_RELU_EN      = 0;

    // Every intermediate sum is carried at 64 bits so nothing can wrap before
    // it is clamped into the destination width.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                        input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    function automatic logic signed [63:0] relu(input logic signed [63:0] value);
        if (value < 64'sd0) begin
            return 64'sd0;
        end
        return value;
    endfunction

endpackage

// File: rtl/neuron_layer_mac_lane.sv
// -----------------------------------------------------------------------------
// mac_lane
// One neuron lane: signed multiply, arithmetic right shift, saturating
// accumulate, then bias add / optional ReLU / output saturation.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears acc and sum)
//   clear_i       : zero the accumulator (start of a new vector)
//   acc_en_i      : accumulate data_i*weight_i >>> SHIFT this cycle
//   final_en_i    : register sat_OUT(acc + bias_i) (ReLU applied if enabled)
//   data_i        : signed input sample
//   weight_i      : signed weight for this lane
//   bias_i        : signed bias for this lane
//   sum_o         : registered lane result, held until the next final_en_i
// -----------------------------------------------------------------------------
module mac_lane
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int SHIFT        = DEF_SHIFT,
    parameter int RELU_EN      = DEF_RELU_EN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_i,
    input  logic                           acc_en_i,
    input  logic                           final_en_i,
    input  logic signed [DATA_WIDTH-1:0]   data_i,
    input  logic signed [WEIGHT_WIDTH-1:0] weight_i,
    input  logic signed [OUT_WIDTH-1:0]    bias_i,
    output logic signed [OUT_WIDTH-1:0]    sum_o
);

    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;

    logic signed [PROD_W-1:0]    data_ext;
    logic signed [PROD_W-1:0]    weight_ext;
    logic signed [PROD_W-1:0]    prod;
    logic signed [PROD_W-1:0]    prod_shifted;
    logic signed [63:0]          term_wide;
    logic signed [63:0]          acc_wide;
    logic signed [63:0]          bias_wide;
    logic signed [63:0]          fin_wide;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        // Operands are sign-extended to the full product width so the multiply
        // is exact and signed.
        data_ext     = {{WEIGHT_WIDTH{data_i[DATA_WIDTH-1]}}, data_i};
        weight_ext   = {{DATA_WIDTH{weight_i[WEIGHT_WIDTH-1]}}, weight_i};
        prod         = data_ext * weight_ext;
        // Arithmetic shift: rounds toward minus infinity.
        prod_shifted = prod >>> SHIFT;

        term_wide = {{(64 - PROD_W){prod_shifted[PROD_W-1]}}, prod_shifted};
        acc_wide  = {{(64 - ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
        bias_wide = {{(64 - OUT_WIDTH){bias_i[OUT_WIDTH-1]}}, bias_i};

        fin_wide = acc_wide + bias_wide;
        if (RELU_EN != 0) begin
            fin_wide = relu(fin_wide);
        end

        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = ACC_WIDTH'(sat_to_width(acc_wide + term_wide, ACC_WIDTH));
        end

        sum_d = sum_q;
        if (final_en_i) begin
            sum_d = OUT_WIDTH'(sat_to_width(fin_wide, OUT_WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/neuron_layer_mac.sv
// -----------------------------------------------------------------------------
// neuron_layer_mac
// Fully-connected layer of NUM_NEURONS lanes over a streamed vector of
// NUM_INPUTS samples. Control FSM: IDLE -> ACCUM -> FINAL -> OUTPUT -> IDLE.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a new vector (only honoured in IDLE)
//   busy                : high whenever not IDLE
//   in_valid / in_ready : input handshake; a beat is in_valid && in_ready
//   data_in             : signed input sample
//   weights             : per-lane signed weights, lane n at [n*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   bias                : per-lane signed bias, sampled in FINAL
//   out_valid/out_ready : output handshake
//   sums                : per-lane signed results, lane n at [n*OUT_WIDTH +: OUT_WIDTH]
// -----------------------------------------------------------------------------
module neuron_layer_mac
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS   = DEF_NUM_INPUTS,
    parameter int NUM_NEURONS  = DEF_NUM_NEURONS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int SHIFT        = DEF_SHIFT,
    parameter int RELU_EN      = DEF_RELU_EN
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 busy,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [DATA_WIDTH-1:0]         data_in,
    input  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0]  weights,
    input  logic [NUM_NEURONS*OUT_WIDTH-1:0]     bias,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_NEURONS*OUT_WIDTH-1:0]     sums
);

    localparam int              CNT_W = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_INPUTS - 1);

    layer_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             beat;
    logic             clear;
    logic             final_en;

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign beat      = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        clear       = 1'b0;
        final_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = FINAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FINAL: begin
                final_en    = 1'b1;
                out_valid_d = 1'b1;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                // start is deliberately not looked at here: a new vector can
                // only begin from IDLE, one cycle after the handshake at the
                // earliest.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .ACC_WIDTH   (ACC_WIDTH),
            .OUT_WIDTH   (OUT_WIDTH),
            .SHIFT       (SHIFT),
            .RELU_EN     (RELU_EN)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clear_i   (clear),
            .acc_en_i  (beat),
            .final_en_i(final_en),
            .data_i    (data_in),
            .weight_i  (weights[n*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .bias_i    (bias[n*OUT_WIDTH +: OUT_WIDTH]),
            .sum_o     (sums[n*OUT_WIDTH +: OUT_WIDTH])
        );
    end

endmodule

// File: tb/tb_neuron_layer_mac.sv
module tb_neuron_layer_mac;

    localparam int NI = 8;
    localparam int NL = 3;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int AW = 12;
    localparam int OW = 13;
    localparam int SH = 5;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic                 out_ready;
    logic signed [DW-1:0] data_in;
    logic [NL*WW-1:0]     weights;
    logic [NL*OW-1:0]     bias;
    logic                 busy_a, busy_b;
    logic                 in_ready_a, in_ready_b;
    logic                 out_valid_a, out_valid_b;
    logic [NL*OW-1:0]     sums_a, sums_b;

    // Two instances on the same stimulus: plain and ReLU.
    neuron_layer_mac #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NL), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
        .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH), .RELU_EN(0)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .data_in(data_in),
        .weights(weights), .bias(bias), .out_valid(out_valid_a),
        .out_ready(out_ready), .sums(sums_a)
    );

    neuron_layer_mac #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NL), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
        .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH), .RELU_EN(1)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .data_in(data_in),
        .weights(weights), .bias(bias), .out_valid(out_valid_b),
        .out_ready(out_ready), .sums(sums_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected cycle-level view, maintained by the driver at transaction level.
    bit chk_en   = 1'b0;
    bit exp_busy = 1'b0;
    bit exp_rdy  = 1'b0;
    bit exp_ov   = 1'b0;
    int exp_a[NL];
    int exp_b[NL];

    // Current vector contents.
    int bd[NI];
    int bw[NI][NL];
    int bias_v[NL];

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int clamp(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference: plain integer arithmetic over the stored vector.
    function automatic int model(input int lane, input bit relu_on);
        int acc, p, t;
        acc = 0;
        for (int i = 0; i < NI; i++) begin
            p   = bd[i] * bw[i][lane];
            p   = p >>> SH;
            acc = clamp(acc + p, AW);
        end
        t = acc + bias_v[lane];
        if (relu_on && t < 0) t = 0;
        return clamp(t, OW);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_a", longint'(busy_a), longint'(exp_busy));
            check("busy_b", longint'(busy_b), longint'(exp_busy));
            check("in_ready_a", longint'(in_ready_a), longint'(exp_rdy));
            check("in_ready_b", longint'(in_ready_b), longint'(exp_rdy));
            check("out_valid_a", longint'(out_valid_a), longint'(exp_ov));
            check("out_valid_b", longint'(out_valid_b), longint'(exp_ov));
            for (int l = 0; l < NL; l++) begin
                check($sformatf("sums_a[%0d]", l), longint'($signed(sums_a[l*OW +: OW])), longint'(exp_a[l]));
                check($sformatf("sums_b[%0d]", l), longint'($signed(sums_b[l*OW +: OW])), longint'(exp_b[l]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage();
        logic [31:0] r32;
        logic [63:0] r64;
        r32     = $urandom;
        data_in = r32[DW-1:0];
        r32     = $urandom;
        weights = r32[NL*WW-1:0];
        r64     = {$urandom, $urandom};
        bias    = r64[NL*OW-1:0];
    endtask

    task automatic drive_beat(input int i);
        data_in = DW'(bd[i]);
        for (int l = 0; l < NL; l++) weights[l*WW +: WW] = WW'(bw[i][l]);
    endtask

    task automatic run_vector(input bit stall, input int hold, input bit pulse);
        int  i;
        bit  gap;
        start = 1'b1;
        tick();
        exp_busy = 1'b1;
        exp_rdy  = 1'b1;
        i   = 0;
        gap = 1'b0;
        while (i < NI) begin
            start = pulse;
            if (stall && gap) begin
                in_valid = 1'b0;
                garbage();
                tick();
            end else begin
                in_valid = 1'b1;
                drive_beat(i);
                tick();
                i++;
                if (i == NI) exp_rdy = 1'b0;
            end
            gap = ~gap;
        end
        // FINAL cycle: bias is sampled here only.
        start    = 1'b0;
        in_valid = 1'b0;
        garbage();
        for (int l = 0; l < NL; l++) bias[l*OW +: OW] = OW'(bias_v[l]);
        tick();
        exp_ov = 1'b1;
        for (int l = 0; l < NL; l++) begin
            exp_a[l] = model(l, 1'b0);
            exp_b[l] = model(l, 1'b1);
        end
        garbage();
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = pulse;
            tick();
        end
        out_ready = 1'b1;
        start     = pulse;
        tick();
        exp_ov    = 1'b0;
        exp_busy  = 1'b0;
        out_ready = 1'b0;
        start     = 1'b0;
        tick();
    endtask

    task automatic fill(input int d, input int w0, input int w1, input int w2,
                        input int b0, input int b1, input int b2);
        for (int i = 0; i < NI; i++) begin
            bd[i]    = d;
            bw[i][0] = w0;
            bw[i][1] = w1;
            bw[i][2] = w2;
        end
        bias_v[0] = b0;
        bias_v[1] = b1;
        bias_v[2] = b2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        weights   = '0;
        bias      = '0;
        for (int l = 0; l < NL; l++) begin
            exp_a[l] = 0;
            exp_b[l] = 0;
        end
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Basic: 64*32>>>5 = 64 per beat, 8 beats.
        fill(64, 32, -32, 127, 0, 0, 0);
        check("pin_basic0", model(0, 1'b0), 512);
        check("pin_basic1", model(1, 1'b0), -512);
        check("pin_basic2", model(2, 1'b0), 2032);
        run_vector(1'b0, 0, 1'b0);

        // Same vector with stalls, output backpressure and stray starts.
        run_vector(1'b1, 5, 1'b1);

        // Accumulator saturation (504/beat, -508/beat) and output saturation.
        fill(127, 127, -128, 127, 0, 0, 4095);
        check("pin_sat0", model(0, 1'b0), 2047);
        check("pin_sat1", model(1, 1'b0), -2048);
        check("pin_sat2", model(2, 1'b0), 4095);
        run_vector(1'b0, 1, 1'b0);

        // ReLU vs plain on bias-only results.
        fill(0, 55, -77, 3, -10, 10, 0);
        check("pin_relu0", model(0, 1'b1), 0);
        check("pin_relu1", model(1, 1'b1), 10);
        check("pin_norelu0", model(0, 1'b0), -10);
        run_vector(1'b0, 2, 1'b0);

        // Shift rounds toward minus infinity.
        fill(-1, 1, 31, -1, 0, 0, 0);
        check("pin_round0", model(0, 1'b0), -8);
        check("pin_round1", model(1, 1'b0), -8);
        check("pin_round2", model(2, 1'b0), 0);
        run_vector(1'b0, 0, 1'b0);

        // Reset mid-vector: abandon after 2 beats, sums return to zero.
        fill(100, 100, 100, 100, 0, 0, 0);
        start = 1'b1;
        tick();
        start    = 1'b0;
        exp_busy = 1'b1;
        exp_rdy  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            drive_beat(i);
            tick();
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst      = 1'b0;
        exp_busy = 1'b0;
        exp_rdy  = 1'b0;
        exp_ov   = 1'b0;
        for (int l = 0; l < NL; l++) begin
            exp_a[l] = 0;
            exp_b[l] = 0;
        end
        tick();
        fill(1, 32, 32, 32, 0, 0, 0);
        check("pin_fresh", model(0, 1'b0), 8);
        run_vector(1'b0, 0, 1'b0);

        // Randomized vectors.
        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < NI; i++) begin
                bd[i] = int'($urandom_range(0, 255)) - 128;
                for (int l = 0; l < NL; l++) bw[i][l] = int'($urandom_range(0, 255)) - 128;
            end
            for (int l = 0; l < NL; l++) bias_v[l] = int'($urandom_range(0, 8191)) - 4096;
            run_vector(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
